// File: rtl/doc_port_arbiter_if.sv
// Bus bundle between the document-RAM port arbiter, its requesters and the RAM read/write pins.
interface doc_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              clear_start;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_spo;
  logic              busy;
  logic              clear_done;

  // Arbiter side.
  modport slave (
    input  clear_start, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_spo,
    output wr_gnt, rd_gnt, rd_data, rd_valid, mem_a, mem_d, mem_we, busy, clear_done
  );

  // Requester / RAM side.
  modport master (
    output clear_start, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_spo,
    input  wr_gnt, rd_gnt, rd_data, rd_valid, mem_a, mem_d, mem_we, busy, clear_done
  );
endinterface

// File: rtl/doc_port_arbiter.sv
// Shares the document RAM's single read/write port between the clear sweep, editor writes and messenger reads.
// Optional read-starvation guard is built in when DOC_ARB_STARVE_GUARD_EN is defined.
module doc_port_arbiter #(
  parameter int                ADDR_W       = 9,
  parameter int                DATA_W       = 8,
  parameter int                CLEAR_DEPTH  = 512,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = {DATA_W{1'b0}},
  parameter int                STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  doc_port_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Counter is one bit wider than the address so a full 2^ADDR_W sweep does not wrap early.
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(CLEAR_DEPTH - 1);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W:0]   clr_cnt_r;
  logic [ADDR_W:0]   clr_cnt_s;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;

  logic              rd_prio_s;
  logic              wr_gnt_s;
  logic              rd_gnt_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_a_s;
  logic [DATA_W-1:0] mem_d_s;
  logic              clear_done_s;

`ifdef DOC_ARB_STARVE_GUARD_EN
  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_r;
  logic [STARVE_W-1:0] starve_cnt_s;

  assign rd_prio_s = (starve_cnt_r == STARVE_MAX);

  // Count denied read cycles in IDLE, saturating at the limit.
  always_comb begin
    starve_cnt_s = starve_cnt_r;
    if ((state_r != ST_IDLE) || bus.clear_start || !bus.rd_req || rd_gnt_s) begin
      starve_cnt_s = {STARVE_W{1'b0}};
    end else if (starve_cnt_r != STARVE_MAX) begin
      starve_cnt_s = starve_cnt_r + STARVE_W'(1);
    end else begin
      starve_cnt_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_r <= {STARVE_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_s;
    end
  end
`else
  // Strict write-over-read; the limit only has meaning with the guard built in, so this is constant low.
  assign rd_prio_s = (STARVE_LIMIT < 0);
`endif

  // Next state, clear sweep counter and combinational grants / RAM port drive.
  always_comb begin
    state_s      = state_r;
    clr_cnt_s    = clr_cnt_r;
    wr_gnt_s     = 1'b0;
    rd_gnt_s     = 1'b0;
    mem_we_s     = 1'b0;
    mem_a_s      = {ADDR_W{1'b0}};
    mem_d_s      = {DATA_W{1'b0}};
    clear_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.wr_req && !(bus.rd_req && rd_prio_s)) begin
          wr_gnt_s = 1'b1;
          mem_we_s = 1'b1;
          mem_a_s  = bus.wr_addr;
          mem_d_s  = bus.wr_data;
        end else if (bus.rd_req) begin
          rd_gnt_s = 1'b1;
          mem_a_s  = bus.rd_addr;
        end else begin
          mem_we_s = 1'b0;
        end
        // The start cycle itself is an ordinary arbitration cycle; the sweep begins next cycle.
        if (bus.clear_start) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        mem_a_s  = clr_cnt_r[ADDR_W-1:0];
        mem_d_s  = CLEAR_VALUE;
        if (clr_cnt_r == CLR_LAST) begin
          clear_done_s = 1'b1;
          clr_cnt_s    = {(ADDR_W + 1){1'b0}};
          state_s      = ST_IDLE;
        end else begin
          clr_cnt_s    = clr_cnt_r + (ADDR_W + 1)'(1);
          state_s      = ST_CLEAR;
        end
      end
      default: begin
        clr_cnt_s = {(ADDR_W + 1){1'b0}};
        state_s   = ST_IDLE;
      end
    endcase
  end

  // State, sweep counter and registered read-return path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      clr_cnt_r  <= {(ADDR_W + 1){1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      clr_cnt_r  <= clr_cnt_s;
      rd_valid_r <= rd_gnt_s;
      if (rd_gnt_s) begin
        rd_data_r <= bus.mem_spo;
      end
    end
  end

  assign bus.wr_gnt     = wr_gnt_s;
  assign bus.rd_gnt     = rd_gnt_s;
  assign bus.rd_data    = rd_data_r;
  assign bus.rd_valid   = rd_valid_r;
  assign bus.mem_a      = mem_a_s;
  assign bus.mem_d      = mem_d_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.busy       = (state_r == ST_CLEAR);
  assign bus.clear_done = clear_done_s;

endmodule

// File: doc/doc_port_arbiter.md
# doc_port_arbiter

Single-port access controller for the document character RAM. Shares the RAM's read/write port among three users: a built-in clear sweep, the text editor's character writes, and the UART messenger's sequential reads. It sits between those requesters and the RAM's `a`/`d`/`we`/`spo` pins; the VGA read port (`dpra`/`dpo`) is untouched.

## Interface

Parameters:
- `ADDR_W`, 9, RAM address width.
- `DATA_W`, 8, RAM data width.
- `CLEAR_DEPTH`, 512, number of addresses swept by a clear, starting at 0.
- `CLEAR_VALUE`, 8'h00, word written by the clear sweep.
- `STARVE_LIMIT`, 4, consecutive denied read cycles before read gets priority. Used only with the guard compiled in.

Ports (reset is asynchronous and active-high; one clock):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `clear_start` in 1: single-cycle pulse that requests a full clear sweep.
- `wr_req` in 1: editor write request; level, held until granted.
- `wr_addr` in ADDR_W: editor write address.
- `wr_data` in DATA_W: editor write data.
- `wr_gnt` out 1: write performed this cycle.
- `rd_req` in 1: messenger read request; level, held until granted.
- `rd_addr` in ADDR_W: messenger read address.
- `rd_gnt` out 1: read address presented this cycle.
- `rd_data` out DATA_W: registered read data.
- `rd_valid` out 1: `rd_data` is valid; high for one cycle.
- `mem_a` out ADDR_W: RAM address.
- `mem_d` out DATA_W: RAM write data.
- `mem_we` out 1: RAM write enable.
- `mem_spo` in DATA_W: RAM combinational read data.
- `busy` out 1: a clear sweep is in progress.
- `clear_done` out 1: one-cycle pulse on the last clear write.

## Operation

- States:
  - IDLE: arbitrate between write and read.
  - CLEAR: sweep `clr_cnt` from 0 to CLEAR_DEPTH-1.
- IDLE → CLEAR when `clear_start`=1. That same cycle is not a clear write; requests that cycle are still arbitrated normally.
- In CLEAR:
  - Every cycle: `mem_we`=1, `mem_a`=`clr_cnt`, `mem_d`=CLEAR_VALUE, `busy`=1.
  - `wr_gnt`=`rd_gnt`=0.
  - `clear_start` is ignored; there is no restart.
  - On `clr_cnt`=CLEAR_DEPTH-1: `clear_done`=1, next state IDLE, `clr_cnt` cleared.
- IDLE priority: write over read.
  - Write grant: `wr_gnt`=1, `mem_we`=1, `mem_a`=`wr_addr`, `mem_d`=`wr_data`.
  - Read grant: `rd_gnt`=1, `mem_we`=0, `mem_a`=`rd_addr`; `mem_spo` is captured into `rd_data` at the clock edge.
  - No grant: `mem_we`=0, `mem_a`=0, `mem_d`=0.
- Grants are combinational from the requests and the state. A requester deasserts or advances its request in the cycle after it sees its grant.
- `rd_data` holds its value until the next read grant.

## Timing

- Reset values: state IDLE, `clr_cnt`=0, `rd_data`=0, `rd_valid`=0, `clear_done`=0, `busy`=0. The combinational outputs evaluate to 0 because no request is granted.
- Write latency: the RAM is updated at the edge ending the `wr_gnt` cycle.
- Read latency: `rd_valid`=1 with `rd_data` exactly one cycle after the `rd_gnt` cycle.
- Clear duration: exactly CLEAR_DEPTH cycles of `busy`=1. `busy` falls the cycle after `clear_done`.
- Simultaneous `wr_req` and `rd_req` with no guard trip: write granted, read waits.
- Reset mid-clear: the sweep aborts with no resume, and the RAM is left partially cleared. Reset mid-read: `rd_valid` is not issued.
- `clr_cnt` is ADDR_W+1 bits wide so that CLEAR_DEPTH = 2^ADDR_W does not wrap early.

## Configuration

- `DOC_ARB_STARVE_GUARD_EN` defined:
  - `starve_cnt` increments each IDLE cycle in which `rd_req`=1 and `rd_gnt`=0, saturating at STARVE_LIMIT.
  - When `starve_cnt`=STARVE_LIMIT, read wins over write for one grant.
  - `starve_cnt` clears on `rd_gnt`, on `rd_req`=0, on entering CLEAR, and on reset.
- Not defined: strict write-over-read priority and no counter logic.

## Test plan

- Reset, then `wr_req`=1, `wr_addr`=9'h015, `wr_data`=8'h41 → `wr_gnt`=1 that cycle; a subsequent read of 9'h015 returns `rd_data`=8'h41 with `rd_valid` one cycle after `rd_gnt`.
- `clear_start` pulse with CLEAR_DEPTH=512 → `busy` high for 512 cycles, `clear_done` on address 511, and reads of 0, 300 and 511 return 8'h00; requests raised during the sweep are granted only after `busy` falls.
- `wr_req` and `rd_req` asserted together for 1 cycle → write granted first, read granted in the next cycle.
- Guard on, STARVE_LIMIT=4, `wr_req` held high continuously with `rd_req`=1 → `rd_gnt`=1 on the 5th cycle and writes resume the cycle after. Guard off → no `rd_gnt` while `wr_req` stays high.
- `rst` asserted at `clr_cnt`=100 → outputs return to reset values asynchronously, state IDLE; address 200 keeps its pre-clear contents.
- `clear_start` pulsed again at `clr_cnt`=50 → ignored; `clear_done` still occurs at address 511 with total `busy` of 512 cycles.
